// File: rtl/sha2_message_build.sv
// SHA-2 (512-bit block) message padder: appends the '1' bit, zero fill and the 64-bit length.
// Optional MESSAGE_BUILD_LAST_EN adds data_out_last marking the final block of a message.
module sha2_message_build (
  input  logic         clk,
  input  logic         nrst,
  input  logic [511:0] data_in,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  input  logic [63:0]  cfg_size,
  input  logic [1:0]   cfg_scheme,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic [511:0] data_out,
  output logic         data_out_valid,
  input  logic         data_out_ready
`ifdef MESSAGE_BUILD_LAST_EN
  ,
  output logic         data_out_last
`endif
);

  typedef enum logic [1:0] {StIdle, StData, StExtra} state_e;

  state_e       state_q, state_d;
  logic [63:0]  size_q, size_d;
  logic [1:0]   scheme_q, scheme_d;
  logic [63:0]  remaining_q, remaining_d;
  logic [511:0] data_out_q, data_out_d;
  logic         valid_q, valid_d;
`ifdef MESSAGE_BUILD_LAST_EN
  logic         last_q, last_d;
`endif

  logic         out_free;
  logic [9:0]   rem_bits;
  logic [511:0] keep_mask;
  logic [511:0] one_bit;
  logic [511:0] size_field;
  logic [511:0] padded;
  logic         unused_scheme;

  // Scheme is captured for downstream use only; padding does not depend on it.
  assign unused_scheme = ^scheme_q;

  assign out_free   = !valid_q || data_out_ready;
  // Only meaningful on the last word, where remaining is 1..512.
  assign rem_bits   = remaining_q[9:0];
  assign keep_mask  = ~({512{1'b1}} >> rem_bits);
  assign one_bit    = {1'b1, 511'b0} >> rem_bits;
  assign size_field = {448'b0, size_q};
  assign padded     = (data_in & keep_mask) | one_bit |
                      ((rem_bits < 10'd448) ? size_field : 512'b0);

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    scheme_d      = scheme_q;
    remaining_d   = remaining_q;
    data_out_d    = data_out_q;
    valid_d       = valid_q && !data_out_ready;
    data_in_ready = 1'b0;
    cfg_ready     = 1'b0;
`ifdef MESSAGE_BUILD_LAST_EN
    last_d        = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          size_d      = cfg_size;
          scheme_d    = cfg_scheme;
          remaining_d = cfg_size;
          state_d     = (cfg_size == 64'd0) ? StExtra : StData;
        end
      end

      StData: begin
        data_in_ready = out_free;
        if (data_in_valid && out_free) begin
          valid_d = 1'b1;
`ifdef MESSAGE_BUILD_LAST_EN
          last_d  = 1'b0;
`endif
          if (remaining_q > 64'd512) begin
            data_out_d  = data_in;
            remaining_d = remaining_q - 64'd512;
          end else if (remaining_q == 64'd512) begin
            // Word fills the block exactly; the '1' bit goes into the extra block.
            data_out_d  = data_in;
            remaining_d = 64'd0;
            state_d     = StExtra;
          end else begin
            data_out_d  = padded;
            remaining_d = 64'd0;
            if (rem_bits < 10'd448) begin
              state_d = StIdle;
`ifdef MESSAGE_BUILD_LAST_EN
              last_d  = 1'b1;
`endif
            end else begin
              state_d = StExtra;
            end
          end
        end
      end

      StExtra: begin
        if (out_free) begin
          data_out_d = {(size_q[8:0] == 9'd0), 447'b0, size_q};
          valid_d    = 1'b1;
          state_d    = StIdle;
`ifdef MESSAGE_BUILD_LAST_EN
          last_d     = 1'b1;
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= StIdle;
      size_q      <= 64'd0;
      scheme_q    <= 2'd0;
      remaining_q <= 64'd0;
      data_out_q  <= 512'd0;
      valid_q     <= 1'b0;
`ifdef MESSAGE_BUILD_LAST_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      scheme_q    <= scheme_d;
      remaining_q <= remaining_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
`ifdef MESSAGE_BUILD_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
`ifdef MESSAGE_BUILD_LAST_EN
  assign data_out_last  = last_q;
`endif

endmodule

// File: tb/tb_sha2_message_build.sv
// Scoreboard bench for sha2_message_build: directed messages, expected blocks queued at issue time.
module tb_sha2_message_build;

  logic         clk = 1'b0;
  logic         nrst;
  logic [511:0] data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [63:0]  cfg_size;
  logic [1:0]   cfg_scheme;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [511:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready;
`ifdef MESSAGE_BUILD_LAST_EN
  logic         data_out_last;
`endif

  typedef struct packed {
    logic [511:0] d;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ready_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: never ready

  logic [511:0] wa, wb, wc, wd;

  sha2_message_build dut (
    .clk            (clk),
    .nrst           (nrst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .cfg_size       (cfg_size),
    .cfg_scheme     (cfg_scheme),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef MESSAGE_BUILD_LAST_EN
    ,
    .data_out_last  (data_out_last)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       data_out_ready = 1'b1;
      1:       data_out_ready = ~data_out_ready;
      default: data_out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: compares each presented transfer against the head of the scoreboard.
  logic         stall_prev = 1'b0;
  logic [511:0] data_prev = '0;
  always @(negedge clk) begin
    if (nrst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {511'b0, data_out_valid}, {511'b0, 1'b1});
        check("hold_data", data_out, data_prev);
      end
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_block: got %h want none", data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("block_data", data_out, e.d);
`ifdef MESSAGE_BUILD_LAST_EN
          check("block_last", {511'b0, data_out_last}, {511'b0, e.l});
`endif
        end
      end
      stall_prev = data_out_valid && !data_out_ready;
      data_prev  = data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [511:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic send_cfg(input logic [63:0] size);
    bit done = 0;
    cfg_size   = size;
    cfg_scheme = size[1:0];
    cfg_valid  = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        tick();
        done = 1;
      end
    end
    cfg_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_timeout: got no cfg_ready want cfg_ready");
    end
  endtask

  task automatic send_word(input logic [511:0] w);
    bit done = 0;
    data_in       = w;
    data_in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (data_in_ready) begin
        tick();
        done = 1;
      end
    end
    data_in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL word_timeout: got no data_in_ready want data_in_ready");
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    tick();
    tick();
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bit any_ready;
    wa = {8{64'hF0E1_D2C3_B4A5_9687}};
    wb = {16{32'hA5A5_5A5A}};
    wc = {4{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211}};
    wd = {64{8'hC3}};
    nrst = 1'b1;
    data_in = '0;
    data_in_valid = 1'b0;
    cfg_size = '0;
    cfg_scheme = '0;
    cfg_valid = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) tick();
    nrst = 1'b0;
    tick();

    check("rst_data_out", data_out, 512'b0);
    check("rst_valid", {511'b0, data_out_valid}, 512'b0);
    check("rst_in_ready", {511'b0, data_in_ready}, 512'b0);
    check("rst_cfg_ready", {511'b0, cfg_ready}, {511'b0, 1'b1});
`ifdef MESSAGE_BUILD_LAST_EN
    check("rst_last", {511'b0, data_out_last}, 512'b0);
`endif

    // 448 bits: padding spills into an extra length block.
    push({wa[511:64], 1'b1, 63'b0}, 1'b0);
    push({448'b0, 64'd448}, 1'b1);
    send_cfg(64'd448);
    send_word(wa);
    wait_drain();

    // 440 bits: '1' bit and length fit in the single block.
    push({wb[511:72], 1'b1, 7'b0, 64'd440}, 1'b1);
    send_cfg(64'd440);
    send_word(wb);
    wait_drain();
    check("idle_cfg_ready", {511'b0, cfg_ready}, {511'b0, 1'b1});

    // 1024 bits: two pass-through words then a '1'+length block.
    push(wc, 1'b0);
    push(wd, 1'b0);
    push({1'b1, 447'b0, 64'd1024}, 1'b1);
    send_cfg(64'd1024);
    send_word(wc);
    send_word(wd);
    wait_drain();

    // 512 bits: one exact word.
    push(wb, 1'b0);
    push({1'b1, 447'b0, 64'd512}, 1'b1);
    send_cfg(64'd512);
    send_word(wb);
    wait_drain();

    // Empty message: no data consumed even when offered.
    push({1'b1, 511'b0}, 1'b1);
    send_cfg(64'd0);
    data_in = wa;
    data_in_valid = 1'b1;
    any_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_ready |= data_in_ready;
    end
    data_in_valid = 1'b0;
    check("empty_no_in_ready", {511'b0, any_ready}, 512'b0);
    wait_drain();

    // 1000 bits under toggling backpressure: r=488 forces an extra block.
    ready_mode = 1;
    push(wc, 1'b0);
    push({wa[511:24], 1'b1, 23'b0}, 1'b0);
    push({448'b0, 64'd1000}, 1'b1);
    send_cfg(64'd1000);
    send_word(wc);
    send_word(wa);
    wait_drain();
    repeat (4) tick();

    // Reset mid-message discards everything pending.
    ready_mode = 2;
    repeat (2) tick();
    send_cfg(64'd1024);
    send_word(wd);
    tick();
    nrst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_valid", {511'b0, data_out_valid}, 512'b0);
    check("midrst_cfg_ready", {511'b0, cfg_ready}, {511'b0, 1'b1});
    nrst = 1'b0;
    ready_mode = 0;
    tick();
    push({wd[511:504], 1'b1, 439'b0, 64'd8}, 1'b1);
    send_cfg(64'd8);
    send_word(wd);
    wait_drain();
    repeat (5) tick();
    check("final_queue_empty", 512'(exp_q.size()), 512'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
